// File: rtl/rd_burst_fsm.sv
// Read-burst sequencer: one go issues len+1 read beats, each followed by a fixed delay with ws retry.
// Optional feature macro: WS_TIMEOUT_EN (bounded retries per beat, reported on o_err).
module rd_burst_fsm #(
  parameter int BURST_W    = 4,
  parameter int DLY_CYCLES = 1,
  parameter int MAX_RETRY  = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_go,
  input  logic [BURST_W-1:0] i_len,
  input  logic               i_ws,
  input  logic               i_abort,
  output logic               o_rd,
  output logic               o_ds,
  output logic               o_busy,
  output logic [BURST_W-1:0] o_beat_cnt,
  output logic               o_abt,
  output logic               o_err
);

  localparam int DLY_W = $clog2(DLY_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_DLY  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [BURST_W-1:0] r_len, w_len_nxt;
  logic [BURST_W-1:0] r_beat, w_beat_nxt;
  logic [DLY_W-1:0]   r_dly, w_dly_nxt;
  logic               r_abt, w_abt_nxt;
  logic               r_rd, r_ds, r_busy;

`ifdef WS_TIMEOUT_EN
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  logic [RETRY_W-1:0] r_retry, w_retry_nxt;
  logic               r_err, w_err_nxt;
`endif

  // Next-state and datapath updates; abort beats ws, which beats the last-beat check.
  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_beat_nxt  = r_beat;
    w_dly_nxt   = r_dly;
    w_abt_nxt   = r_abt;
`ifdef WS_TIMEOUT_EN
    w_retry_nxt = r_retry;
    w_err_nxt   = r_err;
`endif
    case (r_state)
      S_IDLE: begin
        w_abt_nxt = 1'b0;
`ifdef WS_TIMEOUT_EN
        w_err_nxt = 1'b0;
`endif
        if (i_go) begin
          w_state_nxt = S_READ;
          w_len_nxt   = i_len;
          w_beat_nxt  = {BURST_W{1'b0}};
`ifdef WS_TIMEOUT_EN
          w_retry_nxt = {RETRY_W{1'b0}};
`endif
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_READ: begin
        if (i_abort) begin
          w_state_nxt = S_DONE;
          w_abt_nxt   = 1'b1;
        end else begin
          w_state_nxt = S_DLY;
          w_dly_nxt   = DLY_W'(DLY_CYCLES - 1);
        end
      end
      S_DLY: begin
        if (i_abort) begin
          w_state_nxt = S_DONE;
          w_abt_nxt   = 1'b1;
        end else if (r_dly != {DLY_W{1'b0}}) begin
          w_dly_nxt = r_dly - DLY_W'(1);
        end else if (i_ws) begin
`ifdef WS_TIMEOUT_EN
          if (r_retry == RETRY_W'(MAX_RETRY)) begin
            w_state_nxt = S_DONE;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_READ;
            w_retry_nxt = r_retry + RETRY_W'(1);
          end
`else
          w_state_nxt = S_READ;
`endif
        end else if (r_beat == r_len) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_READ;
          w_beat_nxt  = r_beat + BURST_W'(1);
`ifdef WS_TIMEOUT_EN
          w_retry_nxt = {RETRY_W{1'b0}};
`endif
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_abt_nxt   = 1'b0;
`ifdef WS_TIMEOUT_EN
        w_err_nxt   = 1'b0;
`endif
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_abt_nxt   = 1'b0;
      end
    endcase
  end

  // State, counters and Moore outputs registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_len   <= {BURST_W{1'b0}};
      r_beat  <= {BURST_W{1'b0}};
      r_dly   <= {DLY_W{1'b0}};
      r_abt   <= 1'b0;
      r_rd    <= 1'b0;
      r_ds    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
      r_beat  <= w_beat_nxt;
      r_dly   <= w_dly_nxt;
      r_abt   <= w_abt_nxt;
      r_rd    <= (w_state_nxt == S_READ);
      r_ds    <= (w_state_nxt == S_DONE);
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

`ifdef WS_TIMEOUT_EN
  // Retry counter and timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retry <= {RETRY_W{1'b0}};
      r_err   <= 1'b0;
    end else begin
      r_retry <= w_retry_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

  assign o_rd       = r_rd;
  assign o_ds       = r_ds;
  assign o_busy     = r_busy;
  assign o_beat_cnt = r_beat;
  assign o_abt      = r_abt;

endmodule
